reg_writeback: RTL and testbench
================================

// Module: reg_writeback
// PURPOSE
// - Write-back arbiter: the single writer of the register file's write port
//   (write, rd, write_data).
// - Merges results from two producers onto that port:
//   - ALU results, buffered in a DEPTH-entry FIFO.
//   - Load (mem) results, unbuffered, with priority over the ALU.
// - Keeps same-rd write order intact and drops writes to x0.
// - Sits between the execute/memory stages and the register file.
// PARAMETERS
// - DEPTH  4   ALU result FIFO entries; power of two, >= 2.
// - AW     2   log2(DEPTH); FIFO pointer width.
// PORTS
// - clk         in   1   System clock; all state on posedge.
// - rst         in   1   Synchronous, active-high reset.
// - alu_valid   in   1   ALU result offered.
// - alu_ready   out  1   FIFO can accept; = !full.
// - alu_rd      in   5   ALU destination register.
// - alu_data    in   32  ALU result.
// - mem_valid   in   1   Load result offered.
// - mem_ready   out  1   Load result accepted this cycle.
// - mem_rd      in   5   Load destination register.
// - mem_data    in   32  Load data.
// - write       out  1   Register-file write enable (registered).
// - rd          out  5   Register-file destination (registered).
// - write_data  out  32  Register-file write data (registered).
// - busy        out  1   FIFO non-empty.
// BEHAVIOUR
// - Reset (synchronous, active-high rst at posedge):
//   - write=0, rd=0, write_data=0.
//   - FIFO emptied (rd/wr pointers=0, count=0) -> busy=0, alu_ready=1.
//   - Reset mid-operation discards all queued entries; none is ever written.
// - Handshake: a transfer occurs when valid && ready at posedge.
//   - Producers hold rd/data stable while valid && !ready.
// - ALU path:
//   - Accept with alu_rd!=0 -> push {alu_rd, alu_data} at the FIFO tail.
//   - Accept with alu_rd==0 -> consumed and discarded; no push.
//   - alu_ready depends only on count; a pop in the same cycle does not free a slot early.
// - mem_ready (combinational):
//   - 0 when any valid FIFO entry has rd==mem_rd and mem_rd!=0 (WAW hazard).
//   - 1 otherwise.
//   - This guarantees an older queued ALU write never overwrites a newer load.
// - Write-port arbitration, evaluated each posedge:
//   1. mem_valid && mem_ready && mem_rd!=0
//      -> write<=1, rd<=mem_rd, write_data<=mem_data. FIFO does not pop.
//   2. else FIFO non-empty -> pop head; write<=1, rd/write_data <= head fields.
//   3. else write<=0; rd and write_data hold their previous values.
//   - mem accepted with mem_rd==0 is discarded and does not block a FIFO pop.
// - Latency:
//   - Load: accept at edge N -> write high after edge N (1 cycle).
//   - ALU: push at edge N -> earliest write high after edge N+1 (2 cycles).
// - write is a one-cycle pulse per committed result.
// - At most one register-file write per cycle.
// - FIFO ordering:
//   - Strict in-order pop.
//   - Push and pop in the same cycle are both legal when not full / not empty;
//     count is unchanged.
//   - Pointers wrap modulo DEPTH.
//   - count ranges 0..DEPTH.
// - Empty FIFO: no pop, no bypass; an ALU push waits in the FIFO at least one cycle.
// - Full FIFO: alu_ready=0 until a pop occurs.
// - Sustained mem traffic can starve the ALU FIFO (accepted); the WAW hold
//   guarantees forward progress on a hazard.
// TESTING
// - ALU single: alu rd=3, data=0x11 accepted at edge 1
//   -> write=1, rd=3, write_data=0x11 after edge 2 only; busy=0 after edge 2.
// - Fill/drain (DEPTH=4): mem streams rd=9 every cycle while ALU offers
//   rd=1..5 -> alu_ready=0 after 4 pushes. Stop mem -> writes rd=1,2,3,4,5 in order.
// - Priority: FIFO head rd=6, mem rd=5, data=0xAA same cycle
//   -> write rd=5 data=0xAA, then rd=6 next cycle.
// - WAW hold: FIFO holds rd=7, data=0x1; mem_valid rd=7, data=0x2
//   -> mem_ready=0 until rd=7 drains. Write order: 0x1, then 0x2; final Reg[7]=0x2.
// - x0 drop: alu_rd=0 and mem_rd=0 both accepted (ready=1) -> write never asserts; busy stays 0.
// - Reset mid-op: 3 entries queued, rst high 1 cycle
//   -> write=0, rd=0, write_data=0, busy=0, alu_ready=1; queued entries never written.

Source files
------------

// File: rtl/reg_writeback.sv
// Write-back arbiter: sole driver of the register-file write port.
// Loads win the port; ALU results queue in a small FIFO; x0 writes are dropped.
module reg_writeback #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    output logic        write,
    output logic [4:0]  rd,
    output logic [31:0] write_data,
    output logic        busy
);

    logic [4:0]       r_fifo_rd   [DEPTH];
    logic [31:0]      r_fifo_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_write;
    logic [4:0]       r_rd;
    logic [31:0]      r_wdata;

    logic w_hazard;
    logic w_push;
    logic w_pop;
    logic w_mem_wr;

    // Any queued (older) ALU write to the load's rd must retire before the load.
    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_fifo_rd[i] == mem_rd)) begin
                w_hazard = 1'b1;
            end
        end
    end

    assign alu_ready = (r_count != (AW+1)'(DEPTH));
    assign busy      = (r_count != '0);
    assign mem_ready = !((mem_rd != 5'd0) && w_hazard);

    assign w_push   = alu_valid && alu_ready && (alu_rd != 5'd0);
    assign w_mem_wr = mem_valid && mem_ready && (mem_rd != 5'd0);
    assign w_pop    = !w_mem_wr && busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_write  <= 1'b0;
            r_rd     <= 5'd0;
            r_wdata  <= 32'd0;
        end else begin
            if (w_mem_wr) begin
                r_write <= 1'b1;
                r_rd    <= mem_rd;
                r_wdata <= mem_data;
            end else if (w_pop) begin
                r_write <= 1'b1;
                r_rd    <= r_fifo_rd[r_rd_ptr];
                r_wdata <= r_fifo_data[r_rd_ptr];
            end else begin
                r_write <= 1'b0;
            end

            // Push and pop never target the same slot: push needs !full, pop needs !empty.
            if (w_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + AW'(1);
            end
            if (w_push) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + AW'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wr_ptr]   <= alu_rd;
            r_fifo_data[r_wr_ptr] <= alu_data;
        end
    end

    assign write      = r_write;
    assign rd         = r_rd;
    assign write_data = r_wdata;

endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_reg_writeback;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        write;
    logic [4:0]  rd;
    logic [31:0] write_data;
    logic        busy;

    reg_writeback #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .write(write), .rd(rd), .write_data(write_data), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    logic        exp_write;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    bit          m_mr, m_ar, m_mc;
    int          n_assert = 0;
    int          n_fail   = 0;
    bit          chk_en   = 0;
    logic [4:0]  wlog[$];
    logic [31:0] dreg[32];

    function automatic bit m_hazard(input logic [4:0] r);
        foreach (q[i]) if (q[i].rd == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: loads win, otherwise retire the oldest queued ALU result.
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            exp_write = 1'b0;
            exp_rd    = 5'd0;
            exp_data  = 32'd0;
        end else begin
            m_mr = !((mem_rd != 5'd0) && m_hazard(mem_rd));
            m_ar = (q.size() < DEPTH);
            m_mc = mem_valid && m_mr && (mem_rd != 5'd0);
            if (m_mc) begin
                exp_write = 1'b1;
                exp_rd    = mem_rd;
                exp_data  = mem_data;
            end else if (q.size() > 0) begin
                exp_write = 1'b1;
                exp_rd    = q[0].rd;
                exp_data  = q[0].data;
                void'(q.pop_front());
            end else begin
                exp_write = 1'b0;
            end
            if (alu_valid && m_ar && (alu_rd != 5'd0)) q.push_back('{alu_rd, alu_data});
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("write", 32'(write), 32'(exp_write));
            chk("rd", 32'(rd), 32'(exp_rd));
            chk("write_data", write_data, exp_data);
            chk("busy", 32'(busy), 32'(q.size() != 0));
            chk("alu_ready", 32'(alu_ready), 32'(q.size() < DEPTH));
            chk("mem_ready", 32'(mem_ready), 32'(!((mem_rd != 5'd0) && m_hazard(mem_rd))));
            if (write === 1'b1) begin
                wlog.push_back(rd);
                dreg[rd] = write_data;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_send(input logic [4:0] r, input logic [31:0] d, input int budget);
        bit acc;
        int n;
        alu_valid = 1'b1; alu_rd = r; alu_data = d;
        acc = 1'b0; n = 0;
        while (!acc && n < budget) begin
            @(negedge clk);
            acc = (alu_ready === 1'b1);
            step();
            n++;
        end
        alu_valid = 1'b0;
        n_assert++;
        if (!acc) begin
            n_fail++;
            $display("FAIL alu_send timeout rd=%0d: not accepted within %0d cycles", r, budget);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (n < budget) begin
            @(negedge clk);
            if (busy === 1'b0 && write === 1'b0) break;
            n++;
        end
        n_assert++;
        if (n >= budget) begin
            n_fail++;
            $display("FAIL wait_idle: busy=%0b write=%0b after %0d cycles", busy, write, budget);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit aa, ma;
        logic [4:0] alu_order[$];
        rst = 1'b1;
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 32'd0;
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst write", 32'(write), 32'd0);
        chk("rst rd", 32'(rd), 32'd0);
        chk("rst data", write_data, 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst alu_ready", 32'(alu_ready), 32'd1);

        // ALU single: two-cycle latency
        step();
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
        step();
        alu_valid = 1'b0;
        @(negedge clk);
        chk("t1 no write after edge1", 32'(write), 32'd0);
        chk("t1 busy after edge1", 32'(busy), 32'd1);
        step();
        @(negedge clk);
        chk("t1 write", 32'(write), 32'd1);
        chk("t1 rd", 32'(rd), 32'd3);
        chk("t1 data", write_data, 32'h11);
        chk("t1 busy after edge2", 32'(busy), 32'd0);
        step();
        @(negedge clk);
        chk("t1 pulse", 32'(write), 32'd0);

        // Fill/drain under mem streaming
        step();
        wlog.delete();
        mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h900;
        for (int k = 1; k <= 4; k++) alu_send(5'(k), 32'h100 + 32'(k), 10);
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h105;
        repeat (3) step();
        @(negedge clk);
        chk("fill alu_ready", 32'(alu_ready), 32'd0);
        chk("fill busy", 32'(busy), 32'd1);
        step();
        mem_valid = 1'b0;
        alu_send(5'd5, 32'h105, 10);
        wait_idle(30);
        alu_order.delete();
        foreach (wlog[i]) if (wlog[i] != 5'd9) alu_order.push_back(wlog[i]);
        chk("drain count", 32'(alu_order.size()), 32'd5);
        foreach (alu_order[i]) chk("drain order", 32'(alu_order[i]), 32'(i + 1));

        // Priority: load beats queued ALU head
        step();
        alu_send(5'd6, 32'h66, 10);
        mem_valid = 1'b1; mem_rd = 5'd5; mem_data = 32'hAA;
        step();
        mem_valid = 1'b0;
        @(negedge clk);
        chk("prio mem first rd", 32'(rd), 32'd5);
        chk("prio mem first data", write_data, 32'hAA);
        step();
        @(negedge clk);
        chk("prio alu second rd", 32'(rd), 32'd6);
        chk("prio alu second data", write_data, 32'h66);
        chk("prio write", 32'(write), 32'd1);

        // WAW hold
        step();
        alu_send(5'd7, 32'h1, 10);
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h2;
        @(negedge clk);
        chk("waw mem_ready held", 32'(mem_ready), 32'd0);
        step();
        @(negedge clk);
        chk("waw first data", write_data, 32'h1);
        chk("waw mem_ready released", 32'(mem_ready), 32'd1);
        step();
        mem_valid = 1'b0;
        @(negedge clk);
        chk("waw second data", write_data, 32'h2);
        step();
        @(negedge clk);
        chk("waw final reg7", dreg[7], 32'h2);

        // x0 drop
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
        mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h66;
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            chk("x0 write", 32'(write), 32'd0);
            chk("x0 busy", 32'(busy), 32'd0);
            chk("x0 ready", 32'(alu_ready && mem_ready), 32'd1);
        end
        step();
        alu_valid = 1'b0; mem_valid = 1'b0;

        // Reset mid-operation
        step();
        mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h99;
        for (int k = 10; k <= 12; k++) alu_send(5'(k), 32'h200 + 32'(k), 10);
        mem_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        wlog.delete();
        @(negedge clk);
        chk("midrst write", 32'(write), 32'd0);
        chk("midrst rd", 32'(rd), 32'd0);
        chk("midrst data", write_data, 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst alu_ready", 32'(alu_ready), 32'd1);
        repeat (6) step();
        chk("midrst no stale writes", 32'(wlog.size()), 32'd0);

        // Mixed traffic with producer hold rules, checked by the model
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            aa = alu_valid && (alu_ready === 1'b1);
            ma = mem_valid && (mem_ready === 1'b1);
            step();
            if (!alu_valid || aa) begin
                alu_valid = ($urandom_range(0, 1) == 1);
                alu_rd    = 5'($urandom_range(0, 7));
                alu_data  = $urandom;
            end
            if (!mem_valid || ma) begin
                mem_valid = ($urandom_range(0, 2) == 0);
                mem_rd    = 5'($urandom_range(0, 7));
                mem_data  = $urandom;
            end
        end
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        wait_idle(40);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
